switch_arbiter: RTL

SWITCH_ARBITER -- requirements
Module: switch_arbiter

---
 rtl/switch_arbiter_if.sv | 32 +++
 rtl/switch_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/switch_arbiter_if.sv
// Bundle of handshake and data signals for the 4x4 switch arbiter.
//   master : request side (drives requests and output-ready), sees results
//   slave  : arbiter side (accepts requests, presents buffered packets)
// Signals:
//   req_valid/req_target/req_data : per-input packet offer (target is 2 bits per input)
//   req_ready                     : per-input accept strobe
//   out_valid/out_source/out_data : per-output buffered packet (source is 2 bits per output)
//   out_ready                     : per-output consume strobe
//   grant_cnt                     : 16-bit saturating grant counter per output
interface switch_arbiter_if #(
  parameter int DATA_W = 8
) ();
  logic [3:0]          req_valid;
  logic [7:0]          req_target;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic [3:0]          out_valid;
  logic [7:0]          out_source;
  logic [4*DATA_W-1:0] out_data;
  logic [3:0]          out_ready;
  logic [63:0]         grant_cnt;

  modport master (
    output req_valid, req_target, req_data, out_ready,
    input  req_ready, out_valid, out_source, out_data, grant_cnt
  );

  modport slave (
    input  req_valid, req_target, req_data, out_ready,
    output req_ready, out_valid, out_source, out_data, grant_cnt
  );
endinterface

// File: rtl/switch_arbiter.sv
// 4-input / 4-output switch arbiter with one single-entry buffer per output.
// Each output runs its own round-robin arbitration among the inputs that
// target it; the winner is accepted combinationally (req_ready) and its
// packet lands in the output buffer at the next rising edge.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : switch_arbiter_if slave modport (requests, output buffers, counters)
module switch_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  switch_arbiter_if.slave  bus
);
  localparam int N = 4;

  logic [N-1:0]        buf_valid;
  logic [1:0]          buf_src  [N];
  logic [DATA_W-1:0]   buf_data [N];
  logic [1:0]          ptr      [N];
  logic [15:0]         cnt      [N];

  logic [N-1:0]        open_out;
  logic [N-1:0]        grant_any;
  logic [1:0]          grant_idx [N];
  logic [N-1:0]        ready;

  logic [7:0]          src_flat;
  logic [N*DATA_W-1:0] data_flat;
  logic [63:0]         cnt_flat;

  // An output can take a new packet when empty, or when its current packet
  // is being consumed this cycle (drain and refill together).
  always_comb begin
    open_out = '0;
    for (int j = 0; j < N; j++) begin
      open_out[j] = !buf_valid[j] || bus.out_ready[j];
    end
  end

  // Round-robin search starting just after the last granted input; the
  // last-granted input itself is checked last (k = 4 wraps to ptr + 0).
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    ready     = '0;
    grant_any = '0;
    for (int j = 0; j < N; j++) begin
      grant_idx[j] = '0;
      for (int k = 1; k <= N; k++) begin
        idx = ptr[j] + 2'(k);
        if (!rst && open_out[j] && !grant_any[j] && bus.req_valid[idx] &&
            bus.req_target[{idx, 1'b0} +: 2] == 2'(j)) begin
          grant_any[j] = 1'b1;
          grant_idx[j] = idx;
        end
      end
      if (grant_any[j]) begin
        ready[grant_idx[j]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= '0;
      for (int j = 0; j < N; j++) begin
        buf_src[j]  <= '0;
        buf_data[j] <= '0;
        ptr[j]      <= 2'd3;
        cnt[j]      <= '0;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (grant_any[j]) begin
          buf_valid[j] <= 1'b1;
          buf_src[j]   <= grant_idx[j];
          buf_data[j]  <= bus.req_data[int'(grant_idx[j]) * DATA_W +: DATA_W];
          ptr[j]       <= grant_idx[j];
          if (cnt[j] != 16'hFFFF) begin
            cnt[j] <= cnt[j] + 16'd1;
          end
        end else if (buf_valid[j] && bus.out_ready[j]) begin
          buf_valid[j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    src_flat  = '0;
    data_flat = '0;
    cnt_flat  = '0;
    for (int j = 0; j < N; j++) begin
      src_flat[2*j +: 2]           = buf_src[j];
      data_flat[j*DATA_W +: DATA_W] = buf_data[j];
      cnt_flat[16*j +: 16]         = cnt[j];
    end
  end

  assign bus.req_ready  = ready;
  assign bus.out_valid  = buf_valid;
  assign bus.out_source = src_flat;
  assign bus.out_data   = data_flat;
  assign bus.grant_cnt  = cnt_flat;
endmodule
